// File: rtl/cpu_core.sv
`default_nettype none
// =============================================================================
// Module   : cpu_core
// Brief    : Fetch/decode/execute core with register file, 4-bit-opcode ALU
//            and a registered req/ack memory port.
// Revision : 1.0 - initial release
// =============================================================================
module cpu_core #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    NUM_REGS   = 8,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  halted,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [1:0]            flags
);

  localparam int         c_REG_BITS = $clog2(NUM_REGS);
  localparam logic [3:0] c_OP_LDI   = 4'h1;
  localparam logic [3:0] c_OP_MOV   = 4'h2;
  localparam logic [3:0] c_OP_ADD   = 4'h3;
  localparam logic [3:0] c_OP_SUB   = 4'h4;
  localparam logic [3:0] c_OP_AND   = 4'h5;
  localparam logic [3:0] c_OP_OR    = 4'h6;
  localparam logic [3:0] c_OP_XOR   = 4'h7;
  localparam logic [3:0] c_OP_LD    = 4'h8;
  localparam logic [3:0] c_OP_ST    = 4'h9;
  localparam logic [3:0] c_OP_JMP   = 4'hA;
  localparam logic [3:0] c_OP_JZ    = 4'hB;
  localparam logic [3:0] c_OP_HLT   = 4'hC;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_IMM   = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [15:0]             r_instr, w_instr_nxt;
  logic [WORD_WIDTH-1:0]   r_pc, w_pc_nxt, w_pc_inc;
  logic [1:0]              r_flags, w_flags_nxt;
  logic                    r_mem_req, w_req_nxt;
  logic                    r_mem_we, w_we_nxt;
  logic [WORD_WIDTH-1:0]   r_mem_addr, w_addr_nxt;
  logic [WORD_WIDTH-1:0]   r_mem_wdata, w_wdata_nxt;
  logic [WORD_WIDTH-1:0]   r_regs [NUM_REGS];
  logic                    w_rf_we;
  logic [WORD_WIDTH-1:0]   w_rf_data;
  logic [3:0]              w_op;
  logic [c_REG_BITS-1:0]   w_rd, w_rs;
  logic [WORD_WIDTH-1:0]   w_a, w_b, w_alu;
  logic [WORD_WIDTH:0]     w_sum, w_diff;
  logic                    w_alu_c;
  logic                    w_unused;

  assign w_op     = r_instr[15:12];
  assign w_rd     = r_instr[8 +: c_REG_BITS];
  assign w_rs     = r_instr[4 +: c_REG_BITS];
  assign w_a      = r_regs[w_rd];
  assign w_b      = r_regs[w_rs];
  assign w_pc_inc = r_pc + {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  // Top bit of the widened difference is the unsigned borrow.
  assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
  assign w_unused = ^r_instr;

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (w_op)
      c_OP_ADD: begin
        w_alu   = w_sum[WORD_WIDTH-1:0];
        w_alu_c = w_sum[WORD_WIDTH];
      end
      c_OP_SUB: begin
        w_alu   = w_diff[WORD_WIDTH-1:0];
        w_alu_c = w_diff[WORD_WIDTH];
      end
      c_OP_AND: w_alu = w_a & w_b;
      c_OP_OR:  w_alu = w_a | w_b;
      c_OP_XOR: w_alu = w_a ^ w_b;
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_flags_nxt = r_flags;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_rf_we     = 1'b0;
    w_rf_data   = '0;
    case (r_state)
      S_FETCH: begin
        // Only the first cycle after reset arrives here without a request.
        if (!r_mem_req) begin
          w_req_nxt  = 1'b1;
          w_we_nxt   = 1'b0;
          w_addr_nxt = r_pc;
        end else if (mem_ack) begin
          w_instr_nxt = mem_rdata[15:0];
          w_req_nxt   = 1'b0;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = w_pc_inc;
        case (w_op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
            w_rf_we     = 1'b1;
            w_rf_data   = w_alu;
            w_flags_nxt = {w_alu_c, (w_alu == '0)};
          end
          c_OP_MOV: begin
            w_rf_we   = 1'b1;
            w_rf_data = w_b;
          end
          c_OP_LDI, c_OP_JMP, c_OP_JZ: w_state_nxt = S_IMM;
          c_OP_LD: begin
            w_state_nxt = S_MEM;
            w_addr_nxt  = w_b;
          end
          c_OP_ST: begin
            w_state_nxt = S_MEM;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = w_b;
            w_wdata_nxt = w_a;
          end
          c_OP_HLT: begin
            w_state_nxt = S_HALT;
            w_req_nxt   = 1'b0;
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end
      S_IMM: begin
        if (mem_ack) begin
          w_state_nxt = S_FETCH;
          w_we_nxt    = 1'b0;
          if (w_op == c_OP_LDI) begin
            w_rf_we   = 1'b1;
            w_rf_data = mem_rdata;
            w_pc_nxt  = w_pc_inc;
          end else if (w_op == c_OP_JMP || r_flags[0]) begin
            w_pc_nxt = mem_rdata;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
          w_addr_nxt = w_pc_nxt;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (!r_mem_we) begin
            w_rf_we   = 1'b1;
            w_rf_data = mem_rdata;
          end
          w_state_nxt = S_FETCH;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_pc;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_instr     <= '0;
      r_pc        <= RESET_PC;
      r_flags     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_instr     <= w_instr_nxt;
      r_pc        <= w_pc_nxt;
      r_flags     <= w_flags_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_rd] <= w_rf_data;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = (r_state == S_HALT);
  assign pc        = r_pc;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// =============================================================================
// Module   : tb_cpu_core
// Brief    : Self-checking bench for cpu_core against an instruction-level model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b0;
  logic rst_x = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Main core: 16-bit, 8 registers, waited memory
  logic        mem_req, mem_we, mem_ack, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [1:0]  flags;
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          wait_cfg = 0;
  int          wcnt     = 0;

  assign mem_ack   = mem_req && (wcnt == wait_cfg);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  cpu_core u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .pc(pc), .flags(flags)
  );

  // 32-bit core with 16 registers, zero-wait memory
  logic        x_req, x_we, x_halt;
  logic [31:0] x_addr, x_wdata, x_rdata, x_pc;
  logic [1:0]  x_flags;
  logic [31:0] xmem [0:255];
  assign x_rdata = xmem[x_addr[7:0]];

  cpu_core #(.WORD_WIDTH(32), .NUM_REGS(16)) u_dut32 (
    .clk(clk), .rst(rst_x), .mem_req(x_req), .mem_we(x_we), .mem_addr(x_addr),
    .mem_wdata(x_wdata), .mem_rdata(x_rdata), .mem_ack(x_req),
    .halted(x_halt), .pc(x_pc), .flags(x_flags)
  );

  // 16-bit core with 4 registers, zero-wait memory
  logic        y_req, y_we, y_halt;
  logic [15:0] y_addr, y_wdata, y_rdata, y_pc;
  logic [1:0]  y_flags;
  logic [15:0] ymem [0:255];
  assign y_rdata = ymem[y_addr[7:0]];

  cpu_core #(.WORD_WIDTH(16), .NUM_REGS(4)) u_dut4 (
    .clk(clk), .rst(rst_x), .mem_req(y_req), .mem_we(y_we), .mem_addr(y_addr),
    .mem_wdata(y_wdata), .mem_rdata(y_rdata), .mem_ack(y_req),
    .halted(y_halt), .pc(y_pc), .flags(y_flags)
  );

  logic [15:0] pp;
  logic        first_req;
  logic [15:0] first_addr;
  logic [31:0] wq [$];

  // Reference model state: architectural registers, pc, flags, cycle cost
  logic [15:0] m_r [8];
  logic [15:0] m_pc;
  logic        m_c, m_z, m_halt;
  int          m_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs);
    logic [3:0] o, d, s;
    o = 4'(op); d = 4'(rd); s = 4'(rs);
    return {o, d, s, 4'h0};
  endfunction

  task automatic put(input logic [15:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic emit(input logic [15:0] v);
    put(pp, v);
    pp = pp + 16'd1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    pp = '0;
  endtask

  // Instruction-level interpreter; cost = transfers*(1+wait) + 1 EXEC cycle.
  task automatic model_run(input int w);
    logic [15:0] ins;
    int rd, rs, t;
    m_pc = '0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_cyc = 1;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    for (int step = 0; step < 4000 && !m_halt; step++) begin
      ins  = ref_mem[m_pc];
      m_pc = m_pc + 16'd1;
      rd   = int'(ins[10:8]);
      rs   = int'(ins[6:4]);
      case (ins[15:12])
        4'h1: begin m_r[rd] = ref_mem[m_pc]; m_pc = m_pc + 16'd1; m_cyc += 3 + 2*w; end
        4'h2: begin m_r[rd] = m_r[rs]; m_cyc += 2 + w; end
        4'h3: begin
          t = int'(m_r[rd]) + int'(m_r[rs]);
          m_c = (t > 65535); m_r[rd] = t[15:0]; m_z = (m_r[rd] == 0); m_cyc += 2 + w;
        end
        4'h4: begin
          m_c = (m_r[rd] < m_r[rs]); m_r[rd] = m_r[rd] - m_r[rs];
          m_z = (m_r[rd] == 0); m_cyc += 2 + w;
        end
        4'h5: begin m_r[rd] = m_r[rd] & m_r[rs]; m_c = 0; m_z = (m_r[rd] == 0); m_cyc += 2 + w; end
        4'h6: begin m_r[rd] = m_r[rd] | m_r[rs]; m_c = 0; m_z = (m_r[rd] == 0); m_cyc += 2 + w; end
        4'h7: begin m_r[rd] = m_r[rd] ^ m_r[rs]; m_c = 0; m_z = (m_r[rd] == 0); m_cyc += 2 + w; end
        4'h8: begin m_r[rd] = ref_mem[m_r[rs]]; m_cyc += 3 + 2*w; end
        4'h9: begin ref_mem[m_r[rs]] = m_r[rd]; m_cyc += 3 + 2*w; end
        4'hA: begin m_pc = ref_mem[m_pc]; m_cyc += 3 + 2*w; end
        4'hB: begin
          if (m_z) m_pc = ref_mem[m_pc];
          else     m_pc = m_pc + 16'd1;
          m_cyc += 3 + 2*w;
        end
        4'hC: begin m_halt = 1'b1; m_cyc += 2 + w; end
        default: m_cyc += 2 + w;
      endcase
    end
  endtask

  task automatic start_run(input int w);
    @(negedge clk);
    wait_cfg = w;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_halt(output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    wq.delete();
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        first_req  = mem_req;
        first_addr = mem_addr;
      end
      if (mem_req && mem_we) begin
        wq.push_back({mem_addr, mem_wdata});
        if (mem_ack) mem[mem_addr] = mem_wdata;
      end
      if (halted) done = 1'b1;
    end
    check("halt_reached", 32'(done), 32'd1);
  endtask

  task automatic compare_model(input string tag, input int cyc);
    check({tag, "_cycles"}, cyc, m_cyc);
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_flags"}, 32'(flags), 32'({m_c, m_z}));
    check({tag, "_first_req"}, 32'(first_req), 32'd1);
    check({tag, "_first_addr"}, 32'(first_addr), 32'd0);
    for (int a = 32'h8000; a < 32'h8100; a++)
      check($sformatf("%s_mem%0h", tag, a), 32'(mem[a]), 32'(ref_mem[a]));
    for (int a = 32'h9000; a < 32'h9008; a++)
      check($sformatf("%s_dump%0h", tag, a), 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  task automatic gen_random();
    int kind, rd, rs;
    logic [15:0] a;
    for (int a2 = 32'h8000; a2 < 32'h8100; a2++) put(16'(a2), 16'($urandom));
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 10);
      rd   = $urandom_range(0, 15);
      rs   = $urandom_range(0, 15);
      a    = 16'h8000 + 16'($urandom_range(0, 255));
      case (kind)
        0: begin emit(enc(1, rd, 0)); emit(16'($urandom)); end
        1: emit(enc(2, rd, rs));
        2, 3, 4, 5, 6: emit(enc(kind + 1, rd, rs));
        7: begin emit(enc(1, rs, 0)); emit(a); emit(enc(8, rd, rs)); end
        8: begin emit(enc(1, rs, 0)); emit(a); emit(enc(9, rd, rs)); end
        9: begin
          emit(enc(11, 0, 0));
          emit(pp + 16'd2);
          emit(enc($urandom_range(3, 7), rd, rs));
        end
        default: emit(enc(($urandom_range(0, 1) != 0) ? $urandom_range(13, 15) : 0, rd, rs));
      endcase
    end
    for (int i = 1; i < 8; i++) begin
      emit(enc(1, 0, 0)); emit(16'h9000 + 16'(i)); emit(enc(9, i, 0));
    end
    emit(enc(12, 0, 0));
  endtask

  initial begin
    int  cyc;
    bit  found;

    // Reset state and LDI/ADD program with zero-wait memory
    clear_mem();
    emit(enc(1, 1, 0)); emit(16'd5); emit(enc(1, 2, 0)); emit(16'd3);
    emit(enc(3, 1, 2)); emit(enc(12, 0, 0));
    wait_cfg = 0;
    repeat (3) @(negedge clk);
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_we",    32'(mem_we),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_halt",  32'(halted),    32'd0);
    check("rst_pc",    32'(pc),        32'd0);
    check("rst_flags", 32'(flags),     32'd0);
    rst = 1'b1;
    run_until_halt(cyc);
    check("ldi_add_cycles", cyc, 32'd11);
    check("ldi_add_r1", 32'(u_dut.r_regs[1]), 32'd8);
    model_run(0);
    compare_model("ldi_add", cyc);

    // SUB with equal operands, JZ taken to 0x20
    clear_mem();
    emit(enc(1, 1, 0)); emit(16'd3); emit(enc(1, 2, 0)); emit(16'd3);
    emit(enc(4, 1, 2)); emit(enc(11, 0, 0)); emit(16'h0020);
    put(16'h0008, enc(12, 0, 0)); put(16'h0020, enc(12, 0, 0));
    start_run(0);
    run_until_halt(cyc);
    check("jz_taken_pc", 32'(pc), 32'h21);
    check("jz_taken_flags", 32'(flags), 32'b01);
    model_run(0);
    compare_model("jz_taken", cyc);

    // SUB with borrow, JZ falls through past the immediate
    put(16'h0003, 16'd4);
    start_run(1);
    run_until_halt(cyc);
    check("jz_fall_pc", 32'(pc), 32'h9);
    check("jz_fall_flags", 32'(flags), 32'b10);
    check("sub_borrow_r1", 32'(u_dut.r_regs[1]), 32'hFFFF);
    model_run(1);
    compare_model("jz_fall", cyc);

    // ST then LD with two wait cycles per transfer
    clear_mem();
    emit(enc(1, 1, 0)); emit(16'hBEEF); emit(enc(1, 2, 0)); emit(16'h0040);
    emit(enc(9, 1, 2)); emit(enc(8, 3, 2));
    emit(enc(1, 4, 0)); emit(16'h0041); emit(enc(9, 3, 4)); emit(enc(12, 0, 0));
    start_run(2);
    run_until_halt(cyc);
    check("st_wr_cycles", wq.size(), 32'd6);
    for (int i = 0; i < 3; i++)
      check($sformatf("st_hold%0d", i), wq[i], {16'h0040, 16'hBEEF});
    check("st_mem40", 32'(mem[16'h40]), 32'hBEEF);
    check("ld_back_mem41", 32'(mem[16'h41]), 32'hBEEF);
    model_run(2);
    compare_model("st_ld", cyc);

    // Reset asserted while LD waits for ack
    clear_mem();
    emit(enc(1, 2, 0)); emit(16'h0040); emit(enc(8, 3, 2)); emit(enc(12, 0, 0));
    start_run(3);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_req && !mem_we && mem_addr == 16'h0040) found = 1'b1;
    end
    check("midrst_reached_mem", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req_async", 32'(mem_req), 32'd0);
    check("midrst_addr_async", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_until_halt(cyc);
    model_run(3);
    compare_model("midrst", cyc);

    // Randomized programs against the instruction-level model
    for (int r = 0; r < 4; r++) begin
      int w;
      w = $urandom_range(0, 2);
      clear_mem();
      gen_random();
      start_run(w);
      run_until_halt(cyc);
      model_run(w);
      compare_model($sformatf("rand%0d", r), cyc);
    end

    // 32-bit / 16-register and 4-register variants
    for (int i = 0; i < 256; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    xmem[0] = 32'h0000_1F00; xmem[1] = 32'hFFFF_FFFF; xmem[2] = 32'h0000_3FF0;
    xmem[3] = 32'h0000_1E00; xmem[4] = 32'h0000_0080; xmem[5] = 32'h0000_9FE0;
    xmem[6] = 32'h0000_C000;
    ymem[0] = 16'h1500; ymem[1] = 16'h1234; ymem[2] = 16'h1200; ymem[3] = 16'h0080;
    ymem[4] = 16'h9120; ymem[5] = 16'hC000;
    @(negedge clk);
    rst_x = 1'b1;
    for (int i = 0; i < 200 && !(x_halt && y_halt); i++) begin
      @(posedge clk); #1;
      if (x_req && x_we) xmem[x_addr[7:0]] = x_wdata;
      if (y_req && y_we) ymem[y_addr[7:0]] = y_wdata;
    end
    check("w32_halted", 32'(x_halt), 32'd1);
    check("w32_r15_sum", xmem[8'h80], 32'hFFFF_FFFE);
    check("w32_flags", 32'(x_flags), 32'b10);
    check("w32_pc", x_pc, 32'd7);
    check("r4_halted", 32'(y_halt), 32'd1);
    check("r4_alias_r1", 32'(ymem[8'h80]), 32'h1234);
    check("r4_flags", 32'(y_flags), 32'd0);
    check("r4_pc", 32'(y_pc), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
